// File: rtl/sync_fifo_dist_param_pkg.sv
// Shared constants and constant functions for the distributed-RAM FIFO family.
// Mode encodings and log2 helpers are reused by later FIFO variants.
package sync_fifo_dist_param_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2 usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_dist_param_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_dist_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = sync_fifo_dist_param_pkg::clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] iv_din;
    logic                  i_wr;
    logic                  i_rd;
    logic [DATA_WIDTH-1:0] ov_dout;
    logic                  o_full;
    logic                  o_half_full;
    logic                  o_prog_full;
    logic                  o_empty;
    logic                  o_prog_empty;
    logic [CW-1:0]         ov_count;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output iv_din, i_wr, i_rd,
        input  ov_dout, o_full, o_half_full, o_prog_full, o_empty, o_prog_empty,
        input  ov_count, o_overflow, o_underflow
    );

    modport slave (
        input  iv_din, i_wr, i_rd,
        output ov_dout, o_full, o_half_full, o_prog_full, o_empty, o_prog_empty,
        output ov_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/sync_fifo_dist_param_ram.sv
// Simple dual-port LUT RAM: synchronous write port, asynchronous read port.
module dist_ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [$clog2(DEPTH)-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0]         raddr,
    output logic [DATA_WIDTH-1:0]            rdata
);

    // No reset on the array so it maps onto distributed RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_dist_param.sv
// Parametrised single-clock FIFO on distributed RAM with standard or FWFT read,
// occupancy count, programmable thresholds and sticky over/underflow flags.
module sync_fifo_dist_param
    import sync_fifo_dist_param_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 16,
    parameter int FWFT              = FIFO_MODE_STD,
    parameter int PROG_FULL_THRESH  = 12,
    parameter int PROG_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    sync_fifo_dist_param_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 256) begin : g_bad_depth
        $error("sync_fifo_dist_param: DEPTH must be a power of 2 in 4..256");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
        $error("sync_fifo_dist_param: DATA_WIDTH must be in 1..64");
    end
    if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pfull
        $error("sync_fifo_dist_param: PROG_FULL_THRESH must be in 1..DEPTH");
    end
    if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pempty
        $error("sync_fifo_dist_param: PROG_EMPTY_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_dist_param: FWFT must be 0 or 1");
    end

    function automatic logic [CW-1:0] count_step(
        input logic [CW-1:0] cnt,
        input logic          inc,
        input logic          dec
    );
        case ({inc, dec})
            2'b10:   return cnt + CW'(1);
            2'b01:   return cnt - CW'(1);
            default: return cnt;
        endcase
    endfunction

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full_r;
    logic                  half_full_r;
    logic                  prog_full_r;
    logic                  empty_r;
    logic                  prog_empty_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A write into a full FIFO is only legal when a read frees the slot that same cycle.
    assign wr_acc    = bus.i_wr & (~full_r | bus.i_rd);
    assign rd_acc    = bus.i_rd & ~empty_r;
    assign count_nxt = count_step(count, wr_acc, rd_acc);

    dist_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.iv_din),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full_r       <= 1'b0;
            half_full_r  <= 1'b0;
            prog_full_r  <= 1'b0;
            empty_r      <= 1'b1;
            prog_empty_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            // Flags decode the next-state count so they line up with ov_count.
            full_r       <= (count_nxt == CW'(DEPTH));
            half_full_r  <= (count_nxt >= CW'(DEPTH / 2));
            prog_full_r  <= (count_nxt >= CW'(PROG_FULL_THRESH));
            empty_r      <= (count_nxt == '0);
            prog_empty_r <= (count_nxt <= CW'(PROG_EMPTY_THRESH));
            if (bus.i_wr & full_r & ~bus.i_rd) begin
                overflow_r <= 1'b1;
            end
            if (bus.i_rd & empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head of queue is presented directly; i_rd acknowledges it.
        assign bus.ov_dout = ram_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_p1;

        // Stage p1: registered read data, one cycle after the accepted read.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_p1 <= '0;
            end else if (rd_acc) begin
                dout_p1 <= ram_rdata;
            end
        end

        assign bus.ov_dout = dout_p1;
    end

    assign bus.o_full       = full_r;
    assign bus.o_half_full  = half_full_r;
    assign bus.o_prog_full  = prog_full_r;
    assign bus.o_empty      = empty_r;
    assign bus.o_prog_empty = prog_empty_r;
    assign bus.ov_count     = count;
    assign bus.o_overflow   = overflow_r;
    assign bus.o_underflow  = underflow_r;

endmodule

// File: tb/tb_sync_fifo_dist_param.sv
// Drives a standard-mode and an FWFT-mode FIFO in lockstep against one queue model.
module tb_sync_fifo_dist_param;
    import sync_fifo_dist_param_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          wr;
    logic          rd;

    always #5 clk = ~clk;

    sync_fifo_dist_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_s ();
    sync_fifo_dist_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_f ();

    assign bus_s.iv_din = din;
    assign bus_s.i_wr   = wr;
    assign bus_s.i_rd   = rd;
    assign bus_f.iv_din = din;
    assign bus_f.i_wr   = wr;
    assign bus_f.i_rd   = rd;

    sync_fifo_dist_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (FIFO_MODE_STD),
        .PROG_FULL_THRESH (12), .PROG_EMPTY_THRESH (2)
    ) u_std (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    sync_fifo_dist_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (FIFO_MODE_FWFT),
        .PROG_FULL_THRESH (12), .PROG_EMPTY_THRESH (2)
    ) u_fwft (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f)
    );

    logic [DW-1:0] q[$];
    int            m_count;
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_dout;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("std_count",   64'(bus_s.ov_count),     64'(m_count));
        chk("std_full",    64'(bus_s.o_full),       64'(m_count == DEPTH));
        chk("std_half",    64'(bus_s.o_half_full),  64'(m_count >= DEPTH / 2));
        chk("std_pfull",   64'(bus_s.o_prog_full),  64'(m_count >= 12));
        chk("std_empty",   64'(bus_s.o_empty),      64'(m_count == 0));
        chk("std_pempty",  64'(bus_s.o_prog_empty), 64'(m_count <= 2));
        chk("std_ovf",     64'(bus_s.o_overflow),   64'(m_ovf));
        chk("std_unf",     64'(bus_s.o_underflow),  64'(m_unf));
        chk("std_dout",    64'(bus_s.ov_dout),      64'(m_dout));
        chk("fwft_count",  64'(bus_f.ov_count),     64'(m_count));
        chk("fwft_full",   64'(bus_f.o_full),       64'(m_count == DEPTH));
        chk("fwft_empty",  64'(bus_f.o_empty),      64'(m_count == 0));
        chk("fwft_pempty", 64'(bus_f.o_prog_empty), 64'(m_count <= 2));
        chk("fwft_ovf",    64'(bus_f.o_overflow),   64'(m_ovf));
        chk("fwft_unf",    64'(bus_f.o_underflow),  64'(m_unf));
        if (q.size() > 0) begin
            chk("fwft_dout", 64'(bus_f.ov_dout), 64'(q[0]));
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout  = '0;
    endtask

    // One clock of stimulus; the model predicts acceptance from the pre-edge state.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        bit wacc;
        bit racc;
        wr   = w;
        rd   = r;
        din  = d;
        wacc = w && ((m_count < DEPTH) || r);
        racc = r && (m_count > 0);
        if (w && (m_count == DEPTH) && !r) m_ovf = 1'b1;
        if (r && (m_count == 0)) m_unf = 1'b1;
        @(posedge clk);
        #1;
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(d);
        m_count = q.size();
        wr = 1'b0;
        rd = 1'b0;
        check_state();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr     = 1'b0;
        rd     = 1'b0;
        din    = '0;
        reset  = 1'b1;
        model_reset();
        #2;
        check_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state();

        // Fill to full with 0x01..0x10.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i));
        end

        // Write while full, then simultaneous write+read of 0xAA, then drain.
        step(1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
        end
        chk("last_word_aa", 64'(bus_s.ov_dout), 64'h0AA);

        // Read while empty, then write+read of 0x5A on empty, then read it back.
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        chk("std_5a", 64'(bus_s.ov_dout), 64'h05A);

        // FWFT presentation of a single word.
        step(1'b1, 1'b0, 8'h33);
        chk("fwft_33", 64'(bus_f.ov_dout), 64'h033);
        step(1'b0, 1'b1, 8'h00);

        // Wrap: write+read pairs at random fill levels.
        for (int n = 0; n < 40; n++) begin
            int lvl;
            lvl = int'($urandom_range(0, DEPTH - 1));
            while (m_count < lvl) step(1'b1, 1'b0, DW'($urandom));
            while (m_count > lvl) step(1'b0, 1'b1, 8'h00);
            step(1'b1, 1'b1, DW'($urandom));
        end

        // Asynchronous reset mid-stream at count 7 with a write in flight.
        while (m_count < 7) step(1'b1, 1'b0, DW'($urandom));
        while (m_count > 7) step(1'b0, 1'b1, 8'h00);
        wr  = 1'b1;
        din = 8'hEE;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_state();
        wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state();
        step(1'b1, 1'b0, 8'h77);
        chk("fwft_77", 64'(bus_f.ov_dout), 64'h077);
        step(1'b0, 1'b1, 8'h00);
        chk("std_77", 64'(bus_s.ov_dout), 64'h077);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
